// File: rtl/seq_add_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and FSM state type.
package seq_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_add.sv
// Combinational 4-bit ripple slice: per-bit xor sum, majority carry.
module nibble_add
  import seq_add_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  logic [NIB_W:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < NIB_W; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
  end

  assign co = w_c[NIB_W];

endmodule

// File: rtl/seq_nibble_adder.sv
// Wide adder built from one nibble slice, one nibble per clock, valid/ready on both sides.
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | adding nibble idx, carry held in r_carry
// DONE  | result held until downstream takes it
module seq_nibble_adder
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic [IDX_W-1:0]   r_idx;

  logic [31:0]        w_base;
  logic [NIB_W-1:0]   w_s;
  logic               w_co;
  logic               w_last;

  assign w_base = 32'(r_idx) * NIB_W;
  assign w_last = (r_idx == IDX_W'(NIB - 1));

  nibble_add u_slice (
    .a  (r_a[w_base +: NIB_W]),
    .b  (r_b[w_base +: NIB_W]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are held from capture so upstream may change a/b freely during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
    end else if (r_state == RUN) begin
      r_sum[w_base +: NIB_W] <= w_s;
      r_carry                <= w_co;
      if (w_last) r_cout <= w_co;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_seq_nibble_adder.sv
// Randomized self-checking bench for seq_nibble_adder at WIDTH=16 and WIDTH=4.
module tb_seq_nibble_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        iv16, ir16, ci16, ov16, or16, co16, bz16;
  logic [15:0] a16, b16, s16;
  logic        iv4, ir4, ci4, ov4, or4, co4, bz4;
  logic [3:0]  a4, b4, s4;

  int errors = 0;
  int checks = 0;

  seq_nibble_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(ci16), .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(bz16)
  );

  seq_nibble_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(ci4), .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .busy(bz4)
  );

  // Drives one operation and returns what was observed; callers do the checking.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int stall, input bit junk,
                        output logic [15:0] s, output logic co, output int lat,
                        output bit stable, output bit timeout);
    int guard;
    timeout = 0;
    stable  = 1;
    guard   = 0;
    while (!(w == 16 ? ir16 : ir4) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (w == 16) begin a16 = a; b16 = b; ci16 = cin; iv16 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; ci4 = cin; iv4 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    if (w == 16) begin iv16 = junk; a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom); end
    else begin iv4 = junk; a4 = 4'($urandom); b4 = 4'($urandom); ci4 = 1'($urandom); end
    lat = 0;
    while (!(w == 16 ? ov16 : ov4) && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      timeout = 1;
      s = '0;
      co = 1'b0;
      return;
    end
    s  = (w == 16) ? s16 : {12'h000, s4};
    co = (w == 16) ? co16 : co4;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (w == 16) begin
        if (s16 !== s || co16 !== co || ov16 !== 1'b1 || ir16 !== 1'b0) stable = 0;
        if (junk) begin a16 = 16'($urandom); b16 = 16'($urandom); end
      end else begin
        if ({12'h000, s4} !== s || co4 !== co || ov4 !== 1'b1 || ir4 !== 1'b0) stable = 0;
        if (junk) begin a4 = 4'($urandom); b4 = 4'($urandom); end
      end
    end
    if (w == 16) or16 = 1'b1; else or4 = 1'b1;
    @(negedge clk);
    if (w == 16) begin or16 = 1'b0; iv16 = 1'b0; end
    else begin or4 = 1'b0; iv4 = 1'b0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv16 = 0; ci16 = 0; or16 = 0; a16 = '0; b16 = '0;
    iv4  = 0; ci4  = 0; or4  = 0; a4  = '0; b4  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ir16, ov16, bz16, co16} !== 4'b1000 || s16 !== 16'h0000) begin
      errors++;
      $display("FAIL reset16: got ir/ov/bz/co=%b sum=%h, want 1000 sum=0000", {ir16, ov16, bz16, co16}, s16);
    end
    checks++;
    if ({ir4, ov4, bz4, co4} !== 4'b1000 || s4 !== 4'h0) begin
      errors++;
      $display("FAIL reset4: got ir/ov/bz/co=%b sum=%h, want 1000 sum=0", {ir4, ov4, bz4, co4}, s4);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [3] = '{16'hFFFF, 16'h1234, 16'h0FFF};
    logic [15:0] vb [3] = '{16'h0001, 16'h4321, 16'h0001};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [16:0] exp;
    logic [15:0] s;
    logic co;
    int lat;
    bit st, to;
    for (int i = 0; i < 3; i++) begin
      exp = {1'b0, va[i]} + {1'b0, vb[i]} + 17'(vc[i]);
      run_op(16, va[i], vb[i], vc[i], 0, 0, s, co, lat, st, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL directed_timeout[%0d]: out_valid never rose", i);
      end else if ({co, s} !== exp || lat != 4) begin
        errors++;
        $display("FAIL directed[%0d]: got cout=%b sum=%h lat=%0d, want cout=%b sum=%h lat=4",
                 i, co, s, lat, exp[16], exp[15:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] s;
    logic co;
    int lat;
    bit st, to;
    run_op(16, 16'h1111, 16'h2222, 1'b0, 5, 1, s, co, lat, st, to);
    checks++;
    if (to || {co, s} !== 17'h03333 || !st) begin
      errors++;
      $display("FAIL backpressure: got cout=%b sum=%h stable=%0d timeout=%0d, want cout=0 sum=3333 stable=1",
               co, s, st, to);
    end
    checks++;
    if (ir16 !== 1'b1 || bz16 !== 1'b0 || ov16 !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ir=%b bz=%b ov=%b, want ir=1 bz=0 ov=0", ir16, bz16, ov16);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] s;
    logic co;
    int lat;
    bit st, to, seen;
    a16 = 16'hABCD; b16 = 16'h1357; ci16 = 1'b1; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ir16, ov16, bz16, co16} !== 4'b1000 || s16 !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset: got ir/ov/bz/co=%b sum=%h, want 1000 sum=0000", {ir16, ov16, bz16, co16}, s16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov16 !== 1'b0 || bz16 !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL mid_reset_quiet: got activity after reset, want none");
    end
    run_op(16, 16'h8000, 16'h8000, 1'b0, 0, 0, s, co, lat, st, to);
    checks++;
    if (to || {co, s} !== 17'h10000 || lat != 4) begin
      errors++;
      $display("FAIL after_reset_op: got cout=%b sum=%h lat=%0d, want cout=1 sum=0000 lat=4", co, s, lat);
    end
  endtask

  task automatic test_random(input int w);
    logic [15:0] ra, rb, s;
    logic rc, co;
    logic [16:0] exp;
    int lat, nib;
    bit st, to;
    nib = w / 4;
    for (int i = 0; i < 1000; i++) begin
      ra = (w == 16) ? 16'($urandom) : {12'h000, 4'($urandom)};
      rb = (w == 16) ? 16'($urandom) : {12'h000, 4'($urandom)};
      rc = 1'($urandom);
      exp = {1'b0, ra} + {1'b0, rb} + 17'(rc);
      if (w == 4) exp = {12'h000, exp[4:0]};
      run_op(w, ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), s, co, lat, st, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL rand%0d_timeout[%0d]: out_valid never rose", w, i);
        return;
      end
      if (w == 16 ? ({co, s} !== exp) : ({co, s[3:0]} !== exp[4:0]) || lat != nib || !st) begin
        errors++;
        $display("FAIL rand%0d[%0d]: a=%h b=%h cin=%b got cout=%b sum=%h lat=%0d stable=%0d, want %h lat=%0d",
                 w, i, ra, rb, rc, co, s, lat, st, exp, nib);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random(16);
    test_random(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_nibble_adder.md
Name: seq_nibble_adder

Overview:
- Multi-cycle wide-operand adder. It accepts WIDTH-bit operands through a valid/ready handshake and feeds one 4-bit slice per cycle into a combinational 4-bit full-adder slice.
- The slice carry-out is registered and becomes the next slice's carry-in, so wide sums are built from a single small adder at one nibble per clock.
- Sits between an operand producer upstream and a result consumer downstream. Both sides use valid/ready.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4 and >= 4.
- NIB (derived, not overridable), WIDTH/4, number of slice cycles per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  initial carry-in.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  registered sum.
- cout  output  1  registered final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low on rst_n; all flops clear on the falling edge of rst_n, independent of clk.
- Reset values:
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - sum=0; cout=0; internal a/b capture regs=0, carry reg=0, slice index=0.
- State machine: IDLE, RUN, DONE. Outputs decode from state only: in_ready=(IDLE), out_valid=(DONE), busy=(RUN|DONE).
- IDLE:
  - On in_valid&in_ready at edge E0: capture a, b; carry<=cin; idx<=0; go RUN.
  - in_valid without a handshake changes nothing.
- RUN, one slice per cycle:
  - slice sum = nibble_add(a_q[4*idx+:4], b_q[4*idx+:4], carry).
  - sum[4*idx+:4] <= slice sum; carry <= slice carry-out; idx <= idx+1.
  - On idx==NIB-1: cout <= slice carry-out; go DONE.
  - RUN lasts exactly NIB cycles, so out_valid is first high after edge E0+NIB. For WIDTH=16 that is 4 cycles; for WIDTH=4, 1 cycle.
- DONE:
  - Hold sum and cout stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: go IDLE. No new operand is accepted in the same cycle; in_ready rises the cycle after.
  - Throughput is one operation per NIB+2 cycles minimum.
- Arithmetic: result is {cout,sum} = a+b+cin, modulo 2^(WIDTH+1); no overflow flag.
- Upper nibbles of sum may show the previous result during RUN. sum is defined only while out_valid=1.
- idx width is clog2(NIB), minimum 1 bit. idx never wraps past NIB-1, because the state leaves RUN at NIB-1.
- Operands change after capture: no effect, because a_q/b_q are held.
- Reset mid-RUN or mid-DONE: the operation is abandoned, no out_valid pulse appears, and the block returns to IDLE with the reset values above.
- out_ready high while not in DONE: ignored.

Decomposition:
- Shared package seq_add_pkg:
  - NIB_W=4 slice-width constant.
  - state enum {IDLE, RUN, DONE}.
- One sub-module, nibble_add:
  - Purely combinational 4-bit adder slice; inputs a[3:0], b[3:0], ci; outputs s[3:0], co.
  - Built from per-bit sum = a^b^c and carry = majority(a,b,c).
- Top level contains only FSM, capture regs, index counter, carry reg and result regs.

Test Plan:
- Reset release, WIDTH=16 -> in_ready=1, out_valid=0, busy=0, sum=0x0000, cout=0.
- a=0xFFFF, b=0x0001, cin=0 accepted at E0 -> out_valid rises after E0+4; sum=0x0000, cout=1. Carry propagates through all 4 slices.
- a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; a=0x0FFF, b=0x0001, cin=0 -> sum=0x1000, cout=0. Checks a cross-slice carry.
- Backpressure: result ready with out_ready=0 for 5 cycles -> sum/cout stable, in_ready=0, in_valid ignored. Then out_ready=1 for 1 cycle -> IDLE, and in_ready=1 on the next cycle.
- rst_n low for 1 cycle in the 2nd RUN cycle -> immediate return to IDLE, outputs at reset values, no out_valid. A following operation 0x8000+0x8000 gives sum=0x0000, cout=1.
- 1000 random a/b/cin operations with random out_ready stalls, at WIDTH=16 and WIDTH=4 -> every result matches {cout,sum}=a+b+cin, and latency is exactly NIB cycles from accept to out_valid.
